// File: rtl/stat_display_if.sv
// Bundles the statistics sources, source select, freeze control and the
// seven-segment drive lines shared by stat_display and whatever feeds it.
interface stat_display_if;
  logic [31:0] total;
  logic [31:0] conditional;
  logic [31:0] unconditional;
  logic [31:0] conditional_success;
  logic [31:0] load_use;
  logic [2:0]  sel;
  logic        freeze;
  logic [7:0]  an;
  logic [7:0]  seg;

  modport master (
    output total, conditional, unconditional, conditional_success, load_use,
    output sel, freeze,
    input  an, seg
  );

  modport slave (
    input  total, conditional, unconditional, conditional_success, load_use,
    input  sel, freeze,
    output an, seg
  );
endinterface

// File: rtl/stat_display.sv
// Time-multiplexed 8-digit hex display of one selected 32-bit statistic.
// A snapshot is taken only at the frame boundary so a frame never tears;
// freeze holds the snapshot while the counters keep running. Segment and
// anode lines are active-low and registered, lagging idx/snap by one clock.
module stat_display #(
  parameter int unsigned SCAN_DIV = 100000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input logic           clk,
  input logic           rst,
  stat_display_if.slave bus
);

  localparam int unsigned     DIV_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  // Hex nibble to active-low {dp,g,f,e,d,c,b,a}; dp stays off.
  function automatic logic [7:0] hex_decode(input logic [3:0] nib);
    logic [7:0] code;
    case (nib)
      4'h0:    code = 8'hC0;
      4'h1:    code = 8'hF9;
      4'h2:    code = 8'hA4;
      4'h3:    code = 8'hB0;
      4'h4:    code = 8'h99;
      4'h5:    code = 8'h92;
      4'h6:    code = 8'h82;
      4'h7:    code = 8'hF8;
      4'h8:    code = 8'h80;
      4'h9:    code = 8'h90;
      4'hA:    code = 8'h88;
      4'hB:    code = 8'h83;
      4'hC:    code = 8'hC6;
      4'hD:    code = 8'hA1;
      4'hE:    code = 8'h86;
      4'hF:    code = 8'h8E;
      default: code = 8'hFF;
    endcase
    return code;
  endfunction

  // Position of the most significant nonzero nibble; 0 when the value is 0,
  // so digit 0 is never treated as a leading zero.
  function automatic logic [2:0] msn_pos(input logic [31:0] value);
    logic [2:0] pos;
    pos = 3'd0;
    for (int i = 1; i < 8; i++) begin
      pos = (value[4*i +: 4] != 4'h0) ? 3'(i) : pos;
    end
    return pos;
  endfunction

  logic [DIV_W-1:0] div_r;
  logic [2:0]       idx_r;
  logic [31:0]      snap_r;
  logic             inval_r;
  logic [7:0]       an_r;
  logic [7:0]       seg_r;

  logic             tick_s;
  logic             frame_end_s;
  logic [31:0]      src_s;
  logic             src_valid_s;
  logic [2:0]       msn_s;
  logic [3:0]       digit_s;
  logic [7:0]       an_next_s;
  logic [7:0]       seg_next_s;

  assign tick_s      = (div_r == DIV_LAST);
  assign frame_end_s = tick_s && (idx_r == 3'd7);
  assign msn_s       = msn_pos(snap_r);

  // Pick the counter named by sel; codes 5-7 have no source.
  always_comb begin
    src_s       = 32'h0;
    src_valid_s = 1'b0;
    case (bus.sel)
      3'd0:    begin src_s = bus.total;               src_valid_s = 1'b1; end
      3'd1:    begin src_s = bus.conditional;         src_valid_s = 1'b1; end
      3'd2:    begin src_s = bus.unconditional;       src_valid_s = 1'b1; end
      3'd3:    begin src_s = bus.conditional_success; src_valid_s = 1'b1; end
      3'd4:    begin src_s = bus.load_use;            src_valid_s = 1'b1; end
      default: begin src_s = 32'h0;                   src_valid_s = 1'b0; end
    endcase
  end

  // Scan divider and digit index; idx advances once per digit slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_r <= '0;
      idx_r <= 3'd0;
    end else if (tick_s) begin
      div_r <= '0;
      idx_r <= idx_r + 3'd1;
    end else begin
      div_r <= div_r + DIV_ONE;
    end
  end

  // Frame-boundary snapshot of the selected counter, skipped while frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_r  <= 32'h0;
      inval_r <= 1'b0;
    end else if (frame_end_s && !bus.freeze) begin
      snap_r  <= src_s;
      inval_r <= !src_valid_s;
    end
  end

  // Next anode/segment pattern for the digit currently being scanned.
  always_comb begin
    digit_s   = snap_r[{idx_r, 2'b00} +: 4];
    an_next_s = ~(8'h01 << idx_r);
    if (inval_r) begin
      seg_next_s = 8'hBF;
    end else if (BLANK_LZ && (idx_r > msn_s)) begin
      seg_next_s = 8'hFF;
    end else begin
      seg_next_s = hex_decode(digit_s);
    end
  end

  // Registered display drive, all segments and digits dark in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_r  <= 8'hFF;
      seg_r <= 8'hFF;
    end else begin
      an_r  <= an_next_s;
      seg_r <= seg_next_s;
    end
  end

  assign bus.an  = an_r;
  assign bus.seg = seg_r;

endmodule

// File: doc/stat_display.md
# stat_display

Seven-segment scan driver for the performance counters. It takes the five 32-bit statistics from the operating-parameter counter block and selects one with a switch code. It shows that value as 8 hex digits on a common-anode, time-multiplexed display. A frame-synchronous snapshot register prevents tearing, and a freeze input holds the shown value while counters keep running.

## Interface
- SCAN_DIV, 100000: clocks per digit slot (≥2); the bench uses 4
- BLANK_LZ, 1: 1 = blank leading-zero digits; 0 = show all 8 digits
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- total  in  32  cycle counter
- conditional  in  32  conditional-branch counter
- unconditional  in  32  unconditional-jump counter
- conditional_success  in  32  correctly predicted branch counter
- load_use  in  32  load-use conflict counter
- sel  in  3  source select: 0 total, 1 conditional, 2 unconditional, 3 conditional_success, 4 load_use, 5–7 invalid
- freeze  in  1  1 = hold the current snapshot
- an  out  8  digit enables, active-low; an[0] = rightmost digit
- seg  out  8  segments, active-low, bit order {dp,g,f,e,d,c,b,a}

## Operation
- Divider `div`:
  - Counts 0..SCAN_DIV-1 and wraps.
  - `tick` = (div == SCAN_DIV-1).
- Digit index `idx` (3 bits):
  - Increments on the tick edge.
  - Wraps from 7 to 0.
- Snapshot `snap` (32 bits):
  - Loads on a tick edge where idx == 7 (the frame boundary), only when freeze = 0.
  - sel 0–4 loads the matching counter.
  - sel 5–7 loads 0 and sets the `inval` flag; a valid load clears `inval`.
- Output registers update every clock, from the current idx, snap and inval:
  - an <= ~(1 << idx).
  - seg <= decode(snap[4*idx+3 : 4*idx]).
  - If inval, seg <= 0xBF (dash) on every digit.
  - If BLANK_LZ and idx > position of the most significant nonzero nibble, seg <= 0xFF. Digit 0 is never blanked, so a value of 0 shows "0".
- Hex decode: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, B 83, C C6, D A1, E 86, F 8E.
- dp is always 1 (off).

## Timing
- Reset (asynchronous): div = 0, idx = 0, snap = 0, inval = 0, an = 8'hFF, seg = 8'hFF. Applies immediately, with no clock edge needed.
- First edge after reset release: an = 8'hFE, seg = 8'hC0.
- an and seg lag idx and snap by exactly one clock.
- Each digit is active for SCAN_DIV clocks; a frame is 8×SCAN_DIV clocks.
- Counter-change-to-display latency: at most 8×SCAN_DIV + 1 clocks.
- sel or counter changes within a frame never affect digits of that frame.
- freeze is sampled only at the frame boundary:
  - freeze = 1 at the boundary skips the load.
  - Deasserting freeze takes effect at the next boundary.
- Reset asserted mid-frame abandons the frame. After release, scanning restarts at digit 0 with snap = 0.

## Test plan
- Reset and idle (SCAN_DIV = 4, all inputs 0):
  - During reset, an = FF and seg = FF.
  - After release, an steps FE, FD, FB … 7F every 4 clocks, then back to FE.
  - Digit 0 seg = C0; digits 1–7 seg = FF.
- sel = 0, total = 32'h0000_12AB:
  - First boundary is the 8th tick, 32 clocks after release.
  - Next frame shows digit0 83, digit1 88, digit2 A4, digit3 F9, digits 4–7 FF.
  - With BLANK_LZ = 0, digits 4–7 show C0.
- Freeze:
  - Snapshot 32'h5, then freeze = 1 and total = 32'h7 for 3 frames: digit 0 stays 92.
  - freeze = 0: F8 appears from the following boundary.
- Invalid select: sel = 6 gives all 8 digits seg = BF from the next frame. sel = 4 with load_use = 0 then gives digit0 C0 and the rest FF.
- Mid-frame select change: at idx = 3, sel changes 0→4 (total = 32'h1111_1111, load_use = 32'h2). Digits 3–7 of the current frame show F9. The next frame shows digit0 A4, rest FF.
- Asynchronous reset mid-scan: rst pulses between clock edges at idx = 5. an and seg go to FF without waiting for an edge. After release, the scan restarts at an = FE.
